// File: rtl/frame_pkg.sv
// Shared constants and types for the framed byte transmitter.
//   K28_5          comma byte that opens every frame
//   BYTES_PER_WORD bytes unpacked from each 32-bit FIFO word
//   state_t        transmitter FSM states
package frame_pkg;
  localparam logic [7:0] K28_5          = 8'hBC;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;
endpackage

// File: rtl/word_byte_unpacker.sv
// Splits 32-bit FWFT FIFO words into bytes, MSB first.
//   take        request the next payload byte (byte_nxt is valid this cycle)
//   clr         drop any unsent bytes of the held word (bsel -> 0)
//   uf_clr      clear the sticky underflow flag
//   word        FIFO head word, fifo_empty its empty flag
//   byte_nxt    byte to launch at the coming edge (combinational)
//   fifo_rd_en  registered pop strobe, high in the cycle the word's MSB is on fd
//   underflow   sticky, set when a word was needed but the FIFO was empty
module word_byte_unpacker
  import frame_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic        clr,
  input  logic        uf_clr,
  input  logic [31:0] word,
  input  logic        fifo_empty,
  output logic [7:0]  byte_nxt,
  output logic        fifo_rd_en,
  output logic        underflow
);
  localparam logic [1:0] BSEL_LAST = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  bsel;
  logic [23:0] hold;
  logic        need_word;
  logic        pop;

  assign need_word = take && (bsel == 2'd0);
  assign pop       = need_word && !fifo_empty;

  always_comb begin
    byte_nxt = FILL_BYTE;
    unique case (bsel)
      2'd0:    if (!fifo_empty) byte_nxt = word[31:24];
      2'd1:    byte_nxt = hold[23:16];
      2'd2:    byte_nxt = hold[15:8];
      default: byte_nxt = hold[7:0];
    endcase
  end

  // The FWFT head word is consumed at the edge that launches its MSB; the
  // strobe follows one cycle later so it lines up with that byte on fd and
  // the FIFO advances at the next edge, long before bsel returns to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bsel       <= 2'd0;
      hold       <= 24'd0;
      fifo_rd_en <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      fifo_rd_en <= pop;
      if (clr)
        bsel <= 2'd0;
      else if (pop || (take && bsel != 2'd0))
        bsel <= (bsel == BSEL_LAST) ? 2'd0 : bsel + 2'd1;
      if (pop)
        hold <= word[23:0];
      if (uf_clr)
        underflow <= 1'b0;
      else if (need_word && fifo_empty)
        underflow <= 1'b1;
    end
  end
endmodule

// File: rtl/frame_byte_tx.sv
// Framed byte-stream transmitter. Each frame is a K28.5 header byte followed
// by FRAME_WIDTH-1 payload bytes unpacked from a FWFT FIFO (bits [31:0]).
//   clk, rst           clock, synchronous active-high reset
//   start, stop, mode  run control (mode 1: NFRAMES frames, 0: until stop)
//   fifo_dout/empty    FWFT FIFO head; fifo_rd_en pop strobe
//   fd, fd_valid       byte stream (launched on posedge)
//   busy, done         run status; done is a one-cycle end-of-run pulse
//   underflow          sticky FIFO-starvation flag; frame_cnt frames sent
module frame_byte_tx
  import frame_pkg::*;
#(
  parameter int         FIFO_WIDTH  = 36,
  parameter int         FRAME_WIDTH = 48,
  parameter int         NFRAMES     = 100,
  parameter logic [7:0] FILL_BYTE   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [7:0]            fd,
  output logic                  fd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow,
  output logic [9:0]            frame_cnt
);
  localparam int IDX_W = $clog2(FRAME_WIDTH);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             stop_pend;
  logic             last;
  logic [9:0]       fc_inc;
  logic             take, clr, uf_clr;
  logic [7:0]       byte_nxt;

  // Upper FIFO bits carry sideband that this block does not transmit.
  logic unused_hi;
  assign unused_hi = ^{1'b0, fifo_dout[FIFO_WIDTH-1:32]};

  assign last   = (idx == IDX_W'(FRAME_WIDTH - 1));
  assign fc_inc = (frame_cnt == 10'h3FF) ? frame_cnt : frame_cnt + 10'd1;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    clr       = 1'b0;
    uf_clr    = 1'b0;
    unique case (state)
      IDLE:
        if (start) begin
          state_nxt = HEADER;
          uf_clr    = 1'b1;
        end
      HEADER: begin
        state_nxt = PAYLOAD;
        take      = 1'b1;
      end
      PAYLOAD:
        if (last) begin
          // stop arriving on the final byte still ends the run here
          if ((mode && (frame_cnt + 10'd1 == 10'(NFRAMES))) || stop_pend || stop)
            state_nxt = DONE;
          else
            state_nxt = HEADER;
        end else begin
          take = 1'b1;
        end
      default: begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs are registered from the next state so fd shows BC the cycle
  // after start is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      stop_pend <= 1'b0;
      frame_cnt <= 10'd0;
      fd        <= 8'd0;
      fd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        frame_cnt <= 10'd0;
        stop_pend <= stop;
      end else if (state == HEADER || state == PAYLOAD) begin
        stop_pend <= stop_pend | stop;
      end
      if (take)
        idx <= (state == HEADER) ? IDX_W'(1) : idx + IDX_W'(1);
      if (state == PAYLOAD && last)
        frame_cnt <= fc_inc;
      fd_valid <= (state_nxt == HEADER) || (state_nxt == PAYLOAD);
      busy     <= (state_nxt == HEADER) || (state_nxt == PAYLOAD);
      done     <= (state_nxt == DONE);
      unique case (state_nxt)
        HEADER:  fd <= K28_5;
        PAYLOAD: fd <= byte_nxt;
        default: fd <= 8'd0;
      endcase
    end
  end

  word_byte_unpacker #(.FILL_BYTE(FILL_BYTE)) u_unpack (
    .clk        (clk),
    .rst        (rst),
    .take       (take),
    .clr        (clr),
    .uf_clr     (uf_clr),
    .word       (fifo_dout[31:0]),
    .fifo_empty (fifo_empty),
    .byte_nxt   (byte_nxt),
    .fifo_rd_en (fifo_rd_en),
    .underflow  (underflow)
  );
endmodule

// File: tb/tb_frame_byte_tx.sv
module tb_frame_byte_tx;
  localparam int FW = 48;
  localparam int NF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [35:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en, fd_valid, busy, done, underflow;
  logic [7:0]  fd;
  logic [9:0]  frame_cnt;

  int errs = 0, checks = 0;
  int pops = 0, bad_pops = 0;
  logic [31:0] fq[$];

  logic [7:0] exp_q[$];
  int         exp_pops;
  logic       exp_uf;

  always #5 clk = ~clk;

  frame_byte_tx #(.FIFO_WIDTH(36), .FRAME_WIDTH(FW), .NFRAMES(NF), .FILL_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fd(fd), .fd_valid(fd_valid), .busy(busy), .done(done),
    .underflow(underflow), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FWFT FIFO model: pops at the edge where rd_en is high, head refreshed mid-cycle.
  always @(posedge clk)
    if (fifo_rd_en) begin
      if (fq.size() == 0) bad_pops++;
      else begin
        void'(fq.pop_front());
        pops++;
      end
    end

  always @(negedge clk) begin
    fifo_empty <= (fq.size() == 0);
    if (fq.size() != 0) fifo_dout <= {4'hA, fq[0]};
    else                fifo_dout <= '0;
  end

  // Reference: a frame is BC plus FW-1 bytes drawn from a byte queue fed
  // word by word; an empty FIFO when the queue is dry yields a fill byte.
  task automatic build_exp(input int frames);
    logic [31:0] words[$];
    logic [7:0]  pend[$];
    logic [31:0] w;
    words = fq;
    exp_q.delete();
    exp_pops = 0;
    exp_uf   = 1'b0;
    for (int f = 0; f < frames; f++) begin
      exp_q.push_back(8'hBC);
      for (int b = 1; b < FW; b++) begin
        if (pend.size() == 0 && words.size() != 0) begin
          w = words.pop_front();
          exp_pops++;
          pend.push_back(w[31:24]); pend.push_back(w[23:16]);
          pend.push_back(w[15:8]);  pend.push_back(w[7:0]);
        end
        if (pend.size() != 0) exp_q.push_back(pend.pop_front());
        else begin
          exp_q.push_back(8'h00);
          exp_uf = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input string nm, input logic m, input int stop_at, input logic together,
                     input int restart_at, input int abort_at);
    int frames, p0, n;
    logic [7:0] got[$];
    bit seen_done;
    logic prev_v;
    frames = together ? 1 : (m ? NF : 1000);
    if (stop_at >= 0 && stop_at / FW + 1 < frames) frames = stop_at / FW + 1;
    if (abort_at >= 0) frames = abort_at / FW + 1;
    build_exp(frames);
    p0 = pops;
    @(negedge clk);
    mode = m; start = 1'b1; stop = together;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk({nm, ":hdr_fd"}, 32'(fd), 32'hBC);
    chk({nm, ":uf_cleared"}, 32'(underflow), 32'd0);
    chk({nm, ":fc_cleared"}, 32'(frame_cnt), 32'd0);
    seen_done = 0;
    prev_v = 1'b0;
    for (int cyc = 0; cyc < frames * FW + 10 && !seen_done; cyc++) begin
      if (fd_valid) got.push_back(fd);
      if (done) begin
        seen_done = 1;
        chk({nm, ":done_after_last"}, 32'(prev_v), 32'd1);
        chk({nm, ":done_fdv"}, 32'(fd_valid), 32'd0);
        chk({nm, ":done_busy"}, 32'(busy), 32'd0);
        chk({nm, ":frame_cnt"}, 32'(frame_cnt), 32'(frames));
        chk({nm, ":underflow"}, 32'(underflow), 32'(exp_uf));
        chk({nm, ":pops"}, 32'(pops - p0), 32'(exp_pops));
      end
      prev_v = fd_valid;
      if (abort_at >= 0 && got.size() == abort_at + 1) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({nm, ":rst_fdv"}, 32'(fd_valid), 32'd0);
        chk({nm, ":rst_busy"}, 32'(busy), 32'd0);
        chk({nm, ":rst_rden"}, 32'(fifo_rd_en), 32'd0);
        break;
      end
      stop  = fd_valid && (stop_at >= 0) && (got.size() - 1 == stop_at);
      start = fd_valid && (restart_at >= 0) && (got.size() - 1 == restart_at);
      @(negedge clk);
    end
    stop = 1'b0; start = 1'b0;
    if (abort_at < 0) begin
      chk({nm, ":done_seen"}, 32'(seen_done), 32'd1);
      chk({nm, ":len"}, 32'(got.size()), 32'(exp_q.size()));
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s:byte%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
      if (got[i] !== exp_q[i]) break;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_seq(input int nwords);
    fq.delete();
    for (int i = 0; i < nwords; i++) begin
      logic [7:0] b;
      b = 8'(4 * i);
      fq.push_back({b, b + 8'd1, b + 8'd2, b + 8'd3});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_fd", 32'(fd), 32'd0);
    chk("idle_fdv", 32'(fd_valid), 32'd0);
    chk("idle_rden", 32'(fifo_rd_en), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    fill_seq(24);
    run("seq2", 1'b1, -1, 1'b0, -1, -1);

    fq.delete();
    fq.push_back(32'hDEADBEEF);
    run("uflow", 1'b1, -1, 1'b1, -1, -1);

    fill_seq(40);
    run("stop_f3", 1'b0, 2 * FW + 10, 1'b0, -1, -1);

    fill_seq(20);
    run("abort", 1'b0, -1, 1'b0, -1, 21);
    run("after_rst", 1'b0, -1, 1'b1, -1, -1);

    stop = 1'b1;
    repeat (3) @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_busy", 32'(busy), 32'd0);
    fill_seq(30);
    run("restart", 1'b1, -1, 1'b0, 30, -1);

    for (int r = 0; r < 6; r++) begin
      logic m;
      int sa, ra;
      fq.delete();
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) fq.push_back($urandom);
      m  = 1'($urandom_range(0, 1));
      sa = (!m || $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3 * FW - 1)) : -1;
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FW)) : -1;
      run($sformatf("rnd%0d", r), m, sa, 1'b0, ra, -1);
    end

    chk("pop_while_empty", 32'(bad_pops), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
